// File: rtl/operand_bypass_unit.sv
// Decode-stage operand select with a shifting producer scoreboard and load-use stall detection.
// Optional bypass/stall statistics counters are enabled by defining BYPASS_STATS_EN.
module operand_bypass_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 3,
  parameter int NUM_READ       = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_advance,
  input  logic                               i_flush,
  input  logic                               i_issue_uses_rw,
  input  logic [REG_ADDR_WIDTH-1:0]          i_issue_rw_addr,
  input  logic [DEPTH-1:0]                   i_fill_valid,
  input  logic [DEPTH*DATA_WIDTH-1:0]        i_fill_data,
  input  logic [NUM_READ*REG_ADDR_WIDTH-1:0] i_rd_addr,
  input  logic [NUM_READ*DATA_WIDTH-1:0]     i_rd_regfile,
  input  logic [NUM_READ-1:0]                i_rd_use_imm,
  input  logic [NUM_READ*DATA_WIDTH-1:0]     i_rd_imm,
  output logic [NUM_READ*DATA_WIDTH-1:0]     o_operand,
  output logic [NUM_READ-1:0]                o_bypassed,
`ifdef BYPASS_STATS_EN
  output logic [31:0]                        o_bypass_count,
  output logic [31:0]                        o_stall_count,
`endif
  output logic                               o_stall
);

  logic [DEPTH-1:0]          valid_q, valid_d;
  logic [DEPTH-1:0]          ready_q, ready_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [DATA_WIDTH-1:0]     data_q [DEPTH];
  logic [DATA_WIDTH-1:0]     data_d [DEPTH];

  logic [DEPTH-1:0]          filled_ready;
  logic [DATA_WIDTH-1:0]     filled_data [DEPTH];

  // Fills land in their entry first; an advance then shifts the filled view down one slot.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      filled_ready[k] = ready_q[k];
      filled_data[k]  = data_q[k];
      if (i_fill_valid[k] && valid_q[k]) begin
        filled_ready[k] = 1'b1;
        filled_data[k]  = i_fill_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    valid_d = valid_q;
    ready_d = filled_ready;
    for (int k = 0; k < DEPTH; k++) begin
      addr_d[k] = addr_q[k];
      data_d[k] = filled_data[k];
    end

    if (i_advance) begin
      valid_d[0] = i_issue_uses_rw && (i_issue_rw_addr != '0) && !i_flush;
      addr_d[0]  = i_issue_rw_addr;
      ready_d[0] = 1'b0;
      data_d[0]  = '0;
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        addr_d[k]  = addr_q[k-1];
        ready_d[k] = filled_ready[k-1];
        data_d[k]  = filled_data[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ready_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= addr_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

  logic [NUM_READ-1:0]       port_stall;
  logic                      hit;
  logic                      hit_ready;
  logic [DATA_WIDTH-1:0]     hit_data;
  logic [REG_ADDR_WIDTH-1:0] rd_addr;

  // Scanning oldest-to-youngest lets the youngest match overwrite any older one.
  always_comb begin
    o_operand  = '0;
    o_bypassed = '0;
    port_stall = '0;
    hit        = 1'b0;
    hit_ready  = 1'b0;
    hit_data   = '0;
    rd_addr    = '0;
    for (int r = 0; r < NUM_READ; r++) begin
      rd_addr   = i_rd_addr[r*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      hit       = 1'b0;
      hit_ready = 1'b0;
      hit_data  = '0;
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (valid_q[k] && (addr_q[k] == rd_addr)) begin
          hit       = 1'b1;
          hit_ready = ready_q[k] || i_fill_valid[k];
          hit_data  = i_fill_valid[k] ? i_fill_data[k*DATA_WIDTH +: DATA_WIDTH] : data_q[k];
        end
      end

      o_operand[r*DATA_WIDTH +: DATA_WIDTH] = i_rd_regfile[r*DATA_WIDTH +: DATA_WIDTH];
      if (i_rd_use_imm[r]) begin
        o_operand[r*DATA_WIDTH +: DATA_WIDTH] = i_rd_imm[r*DATA_WIDTH +: DATA_WIDTH];
      end else if ((rd_addr != '0) && hit) begin
        if (hit_ready) begin
          o_operand[r*DATA_WIDTH +: DATA_WIDTH] = hit_data;
          o_bypassed[r] = 1'b1;
        end else begin
          port_stall[r] = 1'b1;
        end
      end
    end
  end

  assign o_stall = |port_stall;

`ifdef BYPASS_STATS_EN
  logic [31:0] bypass_count_q, bypass_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    bypass_count_d = bypass_count_q;
    stall_count_d  = stall_count_q;
    if (i_advance && (|o_bypassed) && (bypass_count_q != 32'hFFFF_FFFF)) begin
      bypass_count_d = bypass_count_q + 32'd1;
    end
    if (o_stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bypass_count_q <= '0;
      stall_count_q  <= '0;
    end else begin
      bypass_count_q <= bypass_count_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign o_bypass_count = bypass_count_q;
  assign o_stall_count  = stall_count_q;
`endif

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Directed self-checking bench for operand_bypass_unit (DEPTH=3, NUM_READ=2, 32-bit data).
module tb_operand_bypass_unit;

  logic        clk;
  logic        rst_n;
  logic        i_advance;
  logic        i_flush;
  logic        i_issue_uses_rw;
  logic [4:0]  i_issue_rw_addr;
  logic [2:0]  i_fill_valid;
  logic [95:0] i_fill_data;
  logic [9:0]  i_rd_addr;
  logic [63:0] i_rd_regfile;
  logic [1:0]  i_rd_use_imm;
  logic [63:0] i_rd_imm;
  logic [63:0] o_operand;
  logic [1:0]  o_bypassed;
  logic        o_stall;
`ifdef BYPASS_STATS_EN
  logic [31:0] o_bypass_count;
  logic [31:0] o_stall_count;
`endif

  int checks;
  int failures;

  operand_bypass_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_advance       (i_advance),
    .i_flush         (i_flush),
    .i_issue_uses_rw (i_issue_uses_rw),
    .i_issue_rw_addr (i_issue_rw_addr),
    .i_fill_valid    (i_fill_valid),
    .i_fill_data     (i_fill_data),
    .i_rd_addr       (i_rd_addr),
    .i_rd_regfile    (i_rd_regfile),
    .i_rd_use_imm    (i_rd_use_imm),
    .i_rd_imm        (i_rd_imm),
    .o_operand       (o_operand),
    .o_bypassed      (o_bypassed),
`ifdef BYPASS_STATS_EN
    .o_bypass_count  (o_bypass_count),
    .o_stall_count   (o_stall_count),
`endif
    .o_stall         (o_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    i_advance       = 1'b0;
    i_flush         = 1'b0;
    i_issue_uses_rw = 1'b0;
    i_issue_rw_addr = '0;
    i_fill_valid    = '0;
    i_fill_data     = '0;
    i_rd_addr       = '0;
    i_rd_regfile    = '0;
    i_rd_use_imm    = '0;
    i_rd_imm        = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called just after a negedge; fills already driven ride along with the advance.
  task automatic issue(input logic [4:0] addr, input logic flush);
    i_advance       = 1'b1;
    i_issue_uses_rw = 1'b1;
    i_issue_rw_addr = addr;
    i_flush         = flush;
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic hold_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    issue(5'd5, 1'b0);
    i_fill_valid = 3'b001;
    i_fill_data[31:0] = 32'h0000_0055;
    hold_cycle();
    i_rd_addr[4:0] = 5'd5;
    i_rd_regfile[31:0] = 32'h0000_1111;
    #1;
    checks++;
    if (o_operand[31:0] !== 32'h0000_0055) begin
      failures++;
      $display("[TB] FAIL reset_preload_fwd actual=%h expected=%h", o_operand[31:0], 32'h55);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_bypassed !== 2'b00 || o_operand[31:0] !== 32'h0000_1111) begin
      failures++;
      $display("[TB] FAIL reset_async_discard actual=%b/%h expected=00/00001111", o_bypassed, o_operand[31:0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    i_rd_addr[4:0] = 5'd5;
    i_rd_regfile[31:0] = 32'h0000_1111;
    #1;
    checks++;
    if (o_operand[31:0] !== 32'h0000_1111 || o_bypassed !== 2'b00 || o_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state actual=%h/%b/%b expected=00001111/00/0", o_operand[31:0], o_bypassed, o_stall);
    end
`ifdef BYPASS_STATS_EN
    checks++;
    if (o_bypass_count !== 32'd0 || o_stall_count !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_counters actual=%0d/%0d expected=0/0", o_bypass_count, o_stall_count);
    end
`endif
  endtask

  task automatic test_ex_forward();
    do_reset();
    issue(5'd3, 1'b0);
    i_fill_valid = 3'b001;
    i_fill_data[31:0] = 32'hDEAD_BEEF;
    i_rd_addr[4:0] = 5'd3;
    #1;
    checks++;
    if (o_operand[31:0] !== 32'hDEAD_BEEF || o_bypassed[0] !== 1'b1 || o_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ex_same_cycle_fwd actual=%h/%b/%b expected=deadbeef/1/0", o_operand[31:0], o_bypassed[0], o_stall);
    end
    hold_cycle();
    idle();
    i_rd_addr[4:0] = 5'd3;
    i_rd_regfile[31:0] = 32'h0000_0333;
    #1;
    checks++;
    if (o_operand[31:0] !== 32'hDEAD_BEEF || o_bypassed[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ex_stored_fwd actual=%h/%b expected=deadbeef/1", o_operand[31:0], o_bypassed[0]);
    end
  endtask

  task automatic test_youngest_wins();
    do_reset();
    issue(5'd4, 1'b0);
    i_fill_valid = 3'b001;
    i_fill_data[31:0] = 32'h0000_2222;
    hold_cycle();
    idle();
    issue(5'd10, 1'b0);
    issue(5'd4, 1'b0);
    i_rd_addr[9:5] = 5'd4;
    i_rd_regfile[63:32] = 32'h0000_9999;
    #1;
    checks++;
    if (o_stall !== 1'b1 || o_bypassed[1] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL youngest_unready_stall actual=%b/%b expected=1/0", o_stall, o_bypassed[1]);
    end
    i_fill_valid = 3'b001;
    i_fill_data[31:0] = 32'h0000_0004;
    hold_cycle();
    idle();
    i_rd_addr[9:5] = 5'd4;
    i_rd_regfile[63:32] = 32'h0000_9999;
    #1;
    checks++;
    if (o_operand[63:32] !== 32'h0000_0004 || o_bypassed[1] !== 1'b1 || o_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL youngest_ready_wins actual=%h/%b/%b expected=00000004/1/0", o_operand[63:32], o_bypassed[1], o_stall);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(5'd7, 1'b0);
    i_rd_addr[4:0] = 5'd7;
    #1;
    checks++;
    if (o_stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL load_use_stall actual=%b expected=1", o_stall);
    end
    hold_cycle();
    #1;
    checks++;
    if (o_stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL load_use_stall_held actual=%b expected=1", o_stall);
    end
    i_fill_valid = 3'b001;
    i_fill_data[31:0] = 32'h0000_0077;
    #1;
    checks++;
    if (o_stall !== 1'b0 || o_operand[31:0] !== 32'h0000_0077 || o_bypassed[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL load_use_release actual=%b/%h expected=0/00000077", o_stall, o_operand[31:0]);
    end
  endtask

  task automatic test_flush_r0_imm();
    do_reset();
    issue(5'd9, 1'b1);
    i_rd_addr[4:0] = 5'd9;
    i_rd_regfile[31:0] = 32'h0000_AAAA;
    #1;
    checks++;
    if (o_operand[31:0] !== 32'h0000_AAAA || o_bypassed[0] !== 1'b0 || o_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_bubble actual=%h/%b/%b expected=0000aaaa/0/0", o_operand[31:0], o_bypassed[0], o_stall);
    end
    idle();
    issue(5'd0, 1'b0);
    i_rd_addr[9:5] = 5'd0;
    i_rd_regfile[63:32] = 32'h0000_BBBB;
    #1;
    checks++;
    if (o_operand[63:32] !== 32'h0000_BBBB || o_bypassed[1] !== 1'b0 || o_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL r0_untracked actual=%h/%b/%b expected=0000bbbb/0/0", o_operand[63:32], o_bypassed[1], o_stall);
    end
    idle();
    issue(5'd9, 1'b0);
    i_rd_addr[4:0] = 5'd9;
    i_rd_use_imm = 2'b01;
    i_rd_imm[31:0] = 32'hFFFF_FFF0;
    #1;
    checks++;
    if (o_operand[31:0] !== 32'hFFFF_FFF0 || o_bypassed[0] !== 1'b0 || o_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL imm_over_unready actual=%h/%b/%b expected=fffffff0/0/0", o_operand[31:0], o_bypassed[0], o_stall);
    end
  endtask

  task automatic test_retire_and_fill_advance();
    do_reset();
    issue(5'd12, 1'b0);
    issue(5'd0, 1'b0);
    issue(5'd0, 1'b0);
    i_fill_valid = 3'b100;
    i_fill_data[95:64] = 32'h0000_1234;
    issue(5'd0, 1'b0);
    i_rd_addr[4:0] = 5'd12;
    i_rd_regfile[31:0] = 32'h0000_CCCC;
    #1;
    checks++;
    if (o_operand[31:0] !== 32'h0000_CCCC || o_bypassed[0] !== 1'b0 || o_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL retire_fill_dropped actual=%h/%b/%b expected=0000cccc/0/0", o_operand[31:0], o_bypassed[0], o_stall);
    end
    do_reset();
    issue(5'd13, 1'b0);
    issue(5'd0, 1'b0);
    i_fill_valid = 3'b010;
    i_fill_data[63:32] = 32'h0000_5678;
    issue(5'd0, 1'b0);
    i_rd_addr[4:0] = 5'd13;
    i_rd_regfile[31:0] = 32'h0000_DDDD;
    #1;
    checks++;
    if (o_operand[31:0] !== 32'h0000_5678 || o_bypassed[0] !== 1'b1 || o_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fill_shifts_to_e2 actual=%h/%b/%b expected=00005678/1/0", o_operand[31:0], o_bypassed[0], o_stall);
    end
  endtask

`ifdef BYPASS_STATS_EN
  task automatic test_stats();
    do_reset();
    issue(5'd7, 1'b0);
    i_rd_addr[4:0] = 5'd7;
    hold_cycle();
    hold_cycle();
    i_fill_valid = 3'b001;
    i_fill_data[31:0] = 32'h0000_0007;
    i_advance = 1'b1;
    hold_cycle();
    idle();
    #1;
    checks++;
    if (o_stall_count !== 32'd2 || o_bypass_count !== 32'd1) begin
      failures++;
      $display("[TB] FAIL stats_counts actual=%0d/%0d expected=2/1", o_stall_count, o_bypass_count);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle();
    test_reset();
    test_ex_forward();
    test_youngest_wins();
    test_load_use();
    test_flush_r0_imm();
    test_retire_and_fill_advance();
`ifdef BYPASS_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
